// File: rtl/dmem_responder_pkg.sv
// Shared constants for dmem_responder: data width, MMIO offsets and host FSM states.
package dmem_responder_pkg;

   localparam int DATA_W = 32;

   localparam logic [3:0] OFS_CNT_LO = 4'd0;
   localparam logic [3:0] OFS_CNT_HI = 4'd1;
   localparam logic [3:0] OFS_RESULT = 4'd8;
   localparam logic [3:0] OFS_DONE   = 4'd9;

   typedef enum logic [1:0] {
      H_IDLE    = 2'd0,
      H_ACCESS  = 2'd1,
      H_ACK     = 2'd2,
      H_RELEASE = 2'd3
   } host_state_e;

endpackage

// File: rtl/dmem_responder_mmio_regs.sv
// MMIO register file: cycle counter/shadow, done/result mailbox and read mux.
// The counter and shadow exist only when DMEM_CYCLE_CNT_EN is defined.
module mmio_regs
   import dmem_responder_pkg::*;
(
   input  logic              clock,
   input  logic              reset,
   input  logic              sel,
   input  logic              wr,
   input  logic [3:0]        offset,
   input  logic [DATA_W-1:0] wdata,
   output logic [DATA_W-1:0] rdata,
   output logic              done,
   output logic [DATA_W-1:0] result
);

   logic              wr_result;
   logic [DATA_W-1:0] cnt_lo;
   logic [DATA_W-1:0] shadow;

   assign wr_result = sel && wr && (offset == OFS_RESULT);

   always_ff @(posedge clock or posedge reset) begin
      if (reset) begin
         done   <= 1'b0;
         result <= '0;
      end else if (wr_result) begin
         done   <= 1'b1;
         result <= wdata;
      end
   end

`ifdef DMEM_CYCLE_CNT_EN
   logic [63:0] counter;
   logic        cnt_clr;
   logic        cnt_snap;

   assign cnt_clr  = sel && wr && (offset == OFS_CNT_LO);
   assign cnt_snap = sel && !wr && (offset == OFS_CNT_LO);
   assign cnt_lo   = counter[31:0];

   // Clear wins over the free-running increment.
   always_ff @(posedge clock or posedge reset) begin
      if (reset) begin
         counter <= '0;
         shadow  <= '0;
      end else begin
         counter <= cnt_clr ? 64'd0 : counter + 64'd1;
         if (cnt_snap) begin
            shadow <= counter[63:32];
         end
      end
   end
`else
   assign cnt_lo = '0;
   assign shadow = '0;
`endif

   always_comb begin
      rdata = '0;
      case (offset)
         OFS_CNT_LO: rdata = cnt_lo;
         OFS_CNT_HI: rdata = shadow;
         OFS_RESULT: rdata = result;
         OFS_DONE:   rdata = {{(DATA_W-1){1'b0}}, done};
         default:    rdata = '0;
      endcase
   end

endmodule

// File: rtl/dmem_responder.sv
// CPU data-port responder: word RAM, MMIO window and a req/ack host port into the same RAM.
// Optional cycle counter in the MMIO window is enabled by DMEM_CYCLE_CNT_EN.
//
// state     | meaning
// H_IDLE    | no host transaction, waiting for hReq
// H_ACCESS  | host access pending; a write waits for a cycle without dWr
// H_ACK     | hAck asserted for exactly this cycle
// H_RELEASE | waiting for hReq to drop so a held request cannot re-trigger
module dmem_responder
   import dmem_responder_pkg::*;
#(
   parameter int          DEPTH_LOG2 = 12,
   parameter logic [15:0] MMIO_TAG   = 16'hFFFF
) (
   input  logic              clock,
   input  logic              reset,
   input  logic [19:0]       dAddr,
   input  logic              dWr,
   input  logic [DATA_W-1:0] dMemIn,
   output logic [DATA_W-1:0] dMemOut,
   input  logic              hReq,
   input  logic              hWr,
   input  logic [19:0]       hAddr,
   input  logic [DATA_W-1:0] hWData,
   output logic              hAck,
   output logic [DATA_W-1:0] hRData,
   output logic              done,
   output logic [DATA_W-1:0] result
);

   localparam int DEPTH = 1 << DEPTH_LOG2;

   logic [DATA_W-1:0]     mem [DEPTH];
   logic                  mmio;
   logic [DEPTH_LOG2-1:0] cpu_idx;
   logic [DEPTH_LOG2-1:0] host_idx;
   logic [DATA_W-1:0]     mmio_rdata;
   logic                  host_wr_go;
   logic                  host_rd_go;
   logic                  unused_haddr;
   host_state_e           state;
   host_state_e           state_nxt;

   assign mmio         = (dAddr[19:4] == MMIO_TAG);
   assign cpu_idx      = dAddr[DEPTH_LOG2-1:0];
   assign host_idx     = hAddr[DEPTH_LOG2-1:0];
   assign unused_haddr = ^hAddr[19:DEPTH_LOG2];

   mmio_regs u_mmio_regs (
      .clock  (clock),
      .reset  (reset),
      .sel    (mmio),
      .wr     (dWr),
      .offset (dAddr[3:0]),
      .wdata  (dMemIn),
      .rdata  (mmio_rdata),
      .done   (done),
      .result (result)
   );

   assign dMemOut = mmio ? mmio_rdata : mem[cpu_idx];

   always_ff @(posedge clock or posedge reset) begin
      if (reset) begin
         state <= H_IDLE;
      end else begin
         state <= state_nxt;
      end
   end

   // The CPU owns the single RAM write port; a host write only goes in a cycle without dWr.
   always_comb begin
      state_nxt  = state;
      host_wr_go = 1'b0;
      host_rd_go = 1'b0;
      case (state)
         H_IDLE: begin
            if (hReq) begin
               state_nxt = H_ACCESS;
            end
         end
         H_ACCESS: begin
            if (!hWr) begin
               host_rd_go = 1'b1;
               state_nxt  = H_ACK;
            end else if (!dWr) begin
               host_wr_go = 1'b1;
               state_nxt  = H_ACK;
            end
         end
         H_ACK: begin
            state_nxt = H_RELEASE;
         end
         H_RELEASE: begin
            if (!hReq) begin
               state_nxt = H_IDLE;
            end
         end
         default: begin
            state_nxt = H_IDLE;
         end
      endcase
   end

   assign hAck = (state == H_ACK);

   always_ff @(posedge clock) begin
      if (dWr && !mmio) begin
         mem[cpu_idx] <= dMemIn;
      end else if (host_wr_go) begin
         mem[host_idx] <= hWData;
      end
   end

   // Host read samples the pre-write word if the CPU writes it on the same edge.
   always_ff @(posedge clock or posedge reset) begin
      if (reset) begin
         hRData <= '0;
      end else if (host_rd_go) begin
         hRData <= mem[host_idx];
      end
   end

endmodule

// File: tb/tb_dmem_responder.sv
// Scoreboard bench for dmem_responder: directed stimulus pushes expectations,
// a negedge monitor compares sampled outputs and every hAck pulse.
module tb_dmem_responder;

   logic        clock;
   logic        reset;
   logic [19:0] dAddr;
   logic        dWr;
   logic [31:0] dMemIn;
   logic [31:0] dMemOut;
   logic        hReq;
   logic        hWr;
   logic [19:0] hAddr;
   logic [31:0] hWData;
   logic        hAck;
   logic [31:0] hRData;
   logic        done;
   logic [31:0] result;

   dmem_responder dut (
      .clock   (clock),
      .reset   (reset),
      .dAddr   (dAddr),
      .dWr     (dWr),
      .dMemIn  (dMemIn),
      .dMemOut (dMemOut),
      .hReq    (hReq),
      .hWr     (hWr),
      .hAddr   (hAddr),
      .hWData  (hWData),
      .hAck    (hAck),
      .hRData  (hRData),
      .done    (done),
      .result  (result)
   );

   localparam int SEL_DOUT   = 0;
   localparam int SEL_DONE   = 1;
   localparam int SEL_RESULT = 2;
   localparam int SEL_HACK   = 3;
   localparam int SEL_HRDATA = 4;

   typedef struct {
      string       name;
      int          sel;
      logic [31:0] val;
      int          cyc;
   } chk_t;

   typedef struct {
      string       name;
      int          cyc;
      bit          chk_data;
      logic [31:0] data;
   } ack_t;

   chk_t chk_q[$];
   ack_t ack_q[$];
   int   cyc    = 0;
   int   n_cmp  = 0;
   int   n_err  = 0;

`ifdef DMEM_CYCLE_CNT_EN
   localparam logic [31:0] EXP_CNT10 = 32'd10;
`else
   localparam logic [31:0] EXP_CNT10 = 32'd0;
`endif

   initial clock = 1'b0;
   always #5 clock = ~clock;

   always @(posedge clock) cyc <= cyc + 1;

   always @(negedge clock) begin
      chk_t        c;
      ack_t        a;
      logic [31:0] act;
      while (chk_q.size() > 0 && chk_q[0].cyc <= cyc) begin
         c = chk_q.pop_front();
         case (c.sel)
            SEL_DOUT:   act = dMemOut;
            SEL_DONE:   act = {31'b0, done};
            SEL_RESULT: act = result;
            SEL_HACK:   act = {31'b0, hAck};
            default:    act = hRData;
         endcase
         n_cmp++;
         if (act !== c.val) begin
            n_err++;
            $display("FAIL %s: got %h expected %h (cycle %0d)", c.name, act, c.val, cyc);
         end
      end
      if (hAck === 1'b1) begin
         n_cmp++;
         if (ack_q.size() == 0) begin
            n_err++;
            $display("FAIL unexpected_hAck: got hAck=1 at cycle %0d expected no ack", cyc);
         end else begin
            a = ack_q.pop_front();
            if (cyc != a.cyc || (a.chk_data && hRData !== a.data)) begin
               n_err++;
               $display("FAIL %s: got ack cycle %0d hRData %h expected cycle %0d hRData %h",
                        a.name, cyc, hRData, a.cyc, a.data);
            end
         end
      end
   end

   task automatic step();
      @(posedge clock);
      #1;
   endtask

   task automatic expect_val(input string name, input int sel, input logic [31:0] val);
      chk_t c;
      c.name = name;
      c.sel  = sel;
      c.val  = val;
      c.cyc  = cyc;
      chk_q.push_back(c);
   endtask

   task automatic cpu_write(input logic [19:0] addr, input logic [31:0] data);
      dAddr  = addr;
      dMemIn = data;
      dWr    = 1'b1;
      step();
      dWr    = 1'b0;
   endtask

   task automatic cpu_read(input string name, input logic [19:0] addr, input logic [31:0] exp);
      dAddr = addr;
      dWr   = 1'b0;
      expect_val(name, SEL_DOUT, exp);
      step();
   endtask

   task automatic host_start(input string name, input logic wr, input logic [19:0] addr,
                             input logic [31:0] wdata, input int delay, input bit chk,
                             input logic [31:0] rdata);
      ack_t a;
      hReq       = 1'b1;
      hWr        = wr;
      hAddr      = addr;
      hWData     = wdata;
      a.name     = name;
      a.cyc      = cyc + delay;
      a.chk_data = chk;
      a.data     = rdata;
      ack_q.push_back(a);
   endtask

   initial begin
      #500000;
      $display("FAIL watchdog: got no finish expected finish within time limit");
      $fatal(1, "watchdog expired");
   end

   initial begin
      ack_t a;
      reset  = 1'b1;
      dAddr  = 20'hFFFF9;
      dWr    = 1'b0;
      dMemIn = '0;
      hReq   = 1'b0;
      hWr    = 1'b0;
      hAddr  = '0;
      hWData = '0;
      step();
      step();
      expect_val("rst_done",   SEL_DONE,   32'd0);
      expect_val("rst_result", SEL_RESULT, 32'd0);
      expect_val("rst_hAck",   SEL_HACK,   32'd0);
      expect_val("rst_hRData", SEL_HRDATA, 32'd0);
      expect_val("rst_mmio_done_rd", SEL_DOUT, 32'd0);
      step();
      reset = 1'b0;
      step();

      // CPU write/read and index aliasing
      cpu_write(20'h00010, 32'hDEADBEEF);
      cpu_read("cpu_rd_10", 20'h00010, 32'hDEADBEEF);
      cpu_read("cpu_rd_alias_1010", 20'h01010, 32'hDEADBEEF);

      // host write, held request must not re-ack
      host_start("host_wr_20", 1'b1, 20'h00020, 32'h12345678, 2, 1'b0, 32'h0);
      repeat (6) step();
      hReq = 1'b0;
      step();
      cpu_read("cpu_rd_20", 20'h00020, 32'h12345678);

      // host reads, including an MMIO-range address wrapping into RAM
      host_start("host_rd_10", 1'b0, 20'h00010, 32'h0, 2, 1'b1, 32'hDEADBEEF);
      repeat (3) step();
      hReq = 1'b0;
      step();
      cpu_write(20'h00FF0, 32'hCAFE0001);
      host_start("host_rd_wrap_FFFF0", 1'b0, 20'hFFFF0, 32'h0, 2, 1'b1, 32'hCAFE0001);
      repeat (3) step();
      hReq = 1'b0;
      step();

      // same-word collision: CPU holds dWr 3 cycles, host write deferred
      dAddr  = 20'h00030;
      dMemIn = 32'hAAAA0000;
      dWr    = 1'b1;
      host_start("host_wr_collide_30", 1'b1, 20'h00030, 32'h5555FFFF, 4, 1'b0, 32'h0);
      repeat (3) step();
      dWr = 1'b0;
      repeat (3) step();
      hReq = 1'b0;
      step();
      cpu_read("cpu_rd_30_final", 20'h00030, 32'h5555FFFF);

      // done/result mailbox
      cpu_write(20'hFFFF8, 32'h00000007);
      expect_val("done_set", SEL_DONE, 32'd1);
      expect_val("result_7", SEL_RESULT, 32'd7);
      cpu_read("mmio_rd_done", 20'hFFFF9, 32'd1);
      cpu_read("mmio_rd_result", 20'hFFFF8, 32'd7);
      cpu_write(20'hFFFF9, 32'h0);
      cpu_write(20'hFFFF8, 32'h00000099);
      expect_val("done_sticky", SEL_DONE, 32'd1);
      expect_val("result_99", SEL_RESULT, 32'h99);
      cpu_read("mmio_rd_other_ofs", 20'hFFFF5, 32'd0);
      reset = 1'b1;
      #1;
      expect_val("rst2_done",   SEL_DONE,   32'd0);
      expect_val("rst2_result", SEL_RESULT, 32'd0);
      step();
      reset = 1'b0;
      step();

      // cycle counter
      cpu_write(20'hFFFF0, 32'h0);
      dAddr = 20'hFFFF0;
      repeat (10) step();
      cpu_read("cnt_lo_10", 20'hFFFF0, EXP_CNT10);
      cpu_read("cnt_hi_shadow", 20'hFFFF1, 32'd0);

      // reset while a host write is stuck in ACCESS
      cpu_write(20'h00040, 32'h11110000);
      dAddr  = 20'h00044;
      dMemIn = 32'h00000033;
      dWr    = 1'b1;
      hReq   = 1'b1;
      hWr    = 1'b1;
      hAddr  = 20'h00040;
      hWData = 32'h22220000;
      step();
      step();
      reset = 1'b1;
      hReq  = 1'b0;
      dWr   = 1'b0;
      #1;
      expect_val("rst_mid_hAck", SEL_HACK, 32'd0);
      step();
      step();
      reset = 1'b0;
      step();
      cpu_read("rst_mid_ram_40", 20'h00040, 32'h11110000);
      host_start("host_rd_after_rst", 1'b0, 20'h00040, 32'h0, 2, 1'b1, 32'h11110000);
      repeat (4) step();
      hReq = 1'b0;
      repeat (3) step();

      while (ack_q.size() > 0) begin
         a = ack_q.pop_front();
         n_cmp++;
         n_err++;
         $display("FAIL %s: got no hAck expected hAck at cycle %0d", a.name, a.cyc);
      end
      $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
      $finish;
   end

endmodule
